// File: rtl/lbi_row_sequencer_if.sv
// Handshake bundle between the row sequencer, the PRNG and the row-accumulator unit.
// master: the sequencer (drives busy/rnd_en/row_start/row_random/hash_out/hash_vld/err).
// slave : the environment (drives go/rnd_word/row_result/row_vld).
interface lbi_row_sequencer_if #(
  parameter int unsigned RANDOMSIZE = 96,
  parameter int unsigned NROWS      = 16
);
  logic                  go;
  logic                  busy;
  logic                  rnd_en;
  logic [RANDOMSIZE-1:0] rnd_word;
  logic                  row_start;
  logic [RANDOMSIZE-1:0] row_random;
  logic [5:0]            row_result;
  logic                  row_vld;
  logic [6*NROWS-1:0]    hash_out;
  logic                  hash_vld;
  logic                  err;

  modport master (
    input  go, rnd_word, row_result, row_vld,
    output busy, rnd_en, row_start, row_random, hash_out, hash_vld, err
  );

  modport slave (
    output go, rnd_word, row_result, row_vld,
    input  busy, rnd_en, row_start, row_random, hash_out, hash_vld, err
  );
endinterface

// File: rtl/lbi_row_sequencer.sv
// Row sequencer for the LBMIV row-accumulator unit.
// On go it launches NROWS row computations back to back, feeding ROUNDS PRNG words per row,
// collects each 6-bit row result into hash_out[6k+:6] and pulses hash_vld when complete.
// A row unit that fails to answer within WAIT_MAX cycles sets the sticky err flag.
// Ports:
//   clk    - clock, all state on rising edge
//   reset  - asynchronous active-high reset
//   bus    - lbi_row_sequencer_if.master (go/busy, PRNG handshake, row unit handshake, hash)
module lbi_row_sequencer #(
  parameter int unsigned RANDOMSIZE = 96,
  parameter int unsigned ROUNDS     = 53,
  parameter int unsigned NROWS      = 16,
  parameter int unsigned WAIT_MAX   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  lbi_row_sequencer_if.master   bus
);

  localparam int unsigned RcW = (ROUNDS > 1)   ? $clog2(ROUNDS)   : 1;
  localparam int unsigned RiW = (NROWS > 1)    ? $clog2(NROWS)    : 1;
  localparam int unsigned WcW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  localparam logic [RcW-1:0] RndLast  = RcW'(ROUNDS - 1);
  localparam logic [RiW-1:0] RowLast  = RiW'(NROWS - 1);
  localparam logic [WcW-1:0] WaitLast = WcW'(WAIT_MAX - 1);

  typedef enum logic [2:0] {StIdle, StLaunch, StFeed, StWait, StDone} state_e;

  state_e               state_q, state_d;
  logic [RcW-1:0]       rnd_cnt_q, rnd_cnt_d;
  logic [RiW-1:0]       row_idx_q, row_idx_d;
  logic [WcW-1:0]       wait_cnt_q, wait_cnt_d;
  logic [6*NROWS-1:0]   hash_q, hash_d;
  logic                 err_q, err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      rnd_cnt_q  <= '0;
      row_idx_q  <= '0;
      wait_cnt_q <= '0;
      hash_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rnd_cnt_q  <= rnd_cnt_d;
      row_idx_q  <= row_idx_d;
      wait_cnt_q <= wait_cnt_d;
      hash_q     <= hash_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rnd_cnt_d  = rnd_cnt_q;
    row_idx_d  = row_idx_q;
    wait_cnt_d = wait_cnt_q;
    hash_d     = hash_q;
    err_d      = err_q;
    unique case (state_q)
      // DONE also accepts go so a continuously held go relaunches with no idle gap.
      StIdle, StDone: begin
        if (bus.go) begin
          state_d   = StLaunch;
          row_idx_d = '0;
          hash_d    = '0;
          err_d     = 1'b0;
        end else begin
          state_d   = StIdle;
        end
      end
      StLaunch: begin
        state_d   = StFeed;
        rnd_cnt_d = '0;
      end
      StFeed: begin
        rnd_cnt_d = rnd_cnt_q + RcW'(1);
        if (rnd_cnt_q == RndLast) begin
          state_d    = StWait;
          wait_cnt_d = '0;
        end
      end
      StWait: begin
        if (bus.row_vld) begin
          hash_d[6*row_idx_q +: 6] = bus.row_result;
          if (row_idx_q == RowLast) begin
            state_d = StDone;
          end else begin
            row_idx_d = row_idx_q + RiW'(1);
            state_d   = StLaunch;
          end
        end else if (wait_cnt_q == WaitLast) begin
          // Row unit never answered: abandon the hash, keep the partial result.
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_q + WcW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode straight from the state register so reset clears them immediately.
  assign bus.busy       = (state_q != StIdle);
  assign bus.row_start  = (state_q == StLaunch);
  assign bus.rnd_en     = (state_q == StFeed);
  assign bus.row_random = (state_q == StFeed) ? bus.rnd_word : '0;
  assign bus.hash_vld   = (state_q == StDone);
  assign bus.hash_out   = hash_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_lbi_row_sequencer.sv
// Self-checking bench for lbi_row_sequencer: PRNG word array, behavioural row-unit stub,
// negedge monitor and a reference hash computed from the word array with plain arithmetic.
module tb_lbi_row_sequencer;
  localparam int unsigned RS = 96;
  localparam int unsigned ROUNDS = 53;
  localparam int unsigned NROWS = 16;
  localparam int unsigned HW = 6 * NROWS;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lbi_row_sequencer_if #(.RANDOMSIZE(RS), .NROWS(NROWS)) bus ();

  lbi_row_sequencer #(.RANDOMSIZE(RS), .ROUNDS(ROUNDS), .NROWS(NROWS), .WAIT_MAX(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  int unsigned cyc = 0;
  int unsigned go_cyc = 0;
  logic [15:0] msg;
  logic stub_en;
  logic prng_rst;
  logic [RS-1:0] words [0:2047];
  logic [10:0] widx;

  always @(posedge clk) cyc <= cyc + 1;

  // PRNG model: advances on rnd_en, word visible every cycle.
  always @(posedge clk) begin
    if (prng_rst) widx <= '0;
    else if (bus.rnd_en) widx <= widx + 11'd1;
  end
  assign bus.rnd_word = words[widx];

  function automatic logic [5:0] lane_sum(input logic [RS-1:0] w, input logic [15:0] m);
    logic [5:0] s = '0;
    for (int i = 0; i < 16; i++) if (m[i]) s = s + w[6*i +: 6];
    return s;
  endfunction

  // Row unit stub: after start, accumulates the next ROUNDS words, answers one cycle later.
  logic st_act;
  int st_cnt;
  logic [5:0] st_acc;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      st_act <= 1'b0;
      st_cnt <= 0;
      st_acc <= '0;
      bus.row_vld <= 1'b0;
      bus.row_result <= '0;
    end else begin
      bus.row_vld <= 1'b0;
      if (bus.row_start) begin
        st_act <= 1'b1;
        st_cnt <= 0;
        st_acc <= '0;
      end else if (st_act) begin
        st_acc <= st_acc + lane_sum(bus.row_random, msg);
        st_cnt <= st_cnt + 1;
        if (st_cnt == int'(ROUNDS) - 1) begin
          st_act <= 1'b0;
          if (stub_en) begin
            bus.row_vld <= 1'b1;
            bus.row_result <= st_acc + lane_sum(bus.row_random, msg);
          end
        end
      end
    end
  end

  // Monitor (negedge): event counters relative to the accepted go cycle.
  int en_cnt = 0, rs_cnt = 0, rs_bad = 0, hv_cnt = 0, busy_drop = 0, rr_bad = 0;
  int rel_now;
  always_comb rel_now = int'(cyc) - int'(go_cyc);
  always @(negedge clk) begin
    if (bus.rnd_en) en_cnt <= en_cnt + 1;
    if (bus.row_start) begin
      rs_cnt <= rs_cnt + 1;
      if (!(rel_now >= 1 && (rel_now - 1) % 55 == 0 && (rel_now - 1) / 55 < int'(NROWS)))
        rs_bad <= rs_bad + 1;
    end
    if (bus.hash_vld) hv_cnt <= hv_cnt + 1;
    if (!reset && rel_now >= 1 && rel_now <= 881 && !bus.busy) busy_drop <= busy_drop + 1;
    if (bus.row_random !== (bus.rnd_en ? bus.rnd_word : {RS{1'b0}})) rr_bad <= rr_bad + 1;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [HW-1:0] exp_hash(input int base, input int rows);
    logic [HW-1:0] h = '0;
    for (int k = 0; k < rows; k++) begin
      logic [5:0] r = '0;
      for (int j = 0; j < int'(ROUNDS); j++) r = r + lane_sum(words[base + 53*k + j], msg);
      h[6*k +: 6] = r;
    end
    return h;
  endfunction

  task automatic fill_const(input logic [RS-1:0] w);
    for (int i = 0; i < 2048; i++) words[i] = w;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 2048; i++) words[i] = {$urandom, $urandom, $urandom};
  endtask

  task automatic prng_restart();
    prng_rst = 1'b1;
    @(negedge clk);
    prng_rst = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; that cycle becomes cycle 0.
  task automatic start_hash(input bit hold);
    bus.go = 1'b1;
    go_cyc = cyc;
    if (!hold) begin
      @(negedge clk);
      bus.go = 1'b0;
    end
  endtask

  task automatic wait_hv(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (bus.hash_vld) seen = 1'b1;
    end
    check({tag, "_hv_seen"}, 128'(seen), 128'd1);
  endtask

  logic [RS-1:0] ones_w, lane_w;
  logic [HW-1:0] h16, part;
  int en0, rs0, rsb0, hv0, bd0, rr0;

  task automatic snap();
    en0 = en_cnt; rs0 = rs_cnt; rsb0 = rs_bad; hv0 = hv_cnt; bd0 = busy_drop; rr0 = rr_bad;
  endtask

  initial begin
    reset = 1'b1;
    bus.go = 1'b0;
    stub_en = 1'b1;
    prng_rst = 1'b1;
    msg = 16'hFFFF;
    for (int i = 0; i < 16; i++) begin
      ones_w[6*i +: 6] = 6'd1;
      lane_w[6*i +: 6] = 6'(i + 1);
    end
    for (int k = 0; k < int'(NROWS); k++) h16[6*k +: 6] = 6'd16;
    fill_const(ones_w);
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", 128'(bus.busy), 128'd0);
    check("rst_strobes", 128'({bus.rnd_en, bus.row_start, bus.hash_vld, bus.err}), 128'd0);
    check("rst_hash", 128'(bus.hash_out), 128'd0);
    check("rst_row_random", 128'(bus.row_random), 128'd0);
    reset = 1'b0;
    prng_rst = 1'b0;
    @(negedge clk);

    // 1/2: all-ones message, lane value 1
    snap();
    start_hash(1'b0);
    wait_hv("t1");
    check("t1_hv_cycle", 128'(cyc - go_cyc), 128'd881);
    check("t1_hash", 128'(bus.hash_out), 128'(h16));
    repeat (5) @(negedge clk);
    check("t1_hash_hold", 128'(bus.hash_out), 128'(h16));
    check("t1_idle", 128'(bus.busy), 128'd0);
    check("t1_hv_count", 128'(hv_cnt - hv0), 128'd1);
    check("t2_rnd_en_count", 128'(en_cnt - en0), 128'd848);
    check("t2_row_start_count", 128'(rs_cnt - rs0), 128'd16);
    check("t2_row_start_pos", 128'(rs_bad - rsb0), 128'd0);
    check("t1_busy_drop", 128'(busy_drop - bd0), 128'd0);
    check("t1_row_random", 128'(rr_bad - rr0), 128'd0);

    // 3: random data, go held high, then extra go pulses while busy
    msg = 16'($urandom);
    fill_rand();
    prng_restart();
    snap();
    start_hash(1'b1);
    wait_hv("t3a");
    check("t3a_hv_cycle", 128'(cyc - go_cyc), 128'd881);
    check("t3a_hash", 128'(bus.hash_out), 128'(exp_hash(0, 16)));
    go_cyc = go_cyc + 881;
    @(negedge clk);
    check("t3_launch_882", 128'(bus.row_start), 128'd1);
    check("t3_hash_cleared", 128'(bus.hash_out), 128'd0);
    bus.go = 1'b0;
    for (int p = 0; p < 10; p++) begin
      repeat ($urandom_range(20, 60)) @(negedge clk);
      bus.go = 1'b1;
      @(negedge clk);
      bus.go = 1'b0;
    end
    wait_hv("t3b");
    check("t3b_hv_cycle", 128'(cyc - go_cyc), 128'd881);
    check("t3b_hash", 128'(bus.hash_out), 128'(exp_hash(848, 16)));
    repeat (3) @(negedge clk);
    check("t3_rnd_en_count", 128'(en_cnt - en0), 128'd1696);
    check("t3_row_start_count", 128'(rs_cnt - rs0), 128'd32);
    check("t3_row_start_pos", 128'(rs_bad - rsb0), 128'd0);
    check("t3_busy_drop", 128'(busy_drop - bd0), 128'd0);
    check("t3_hv_count", 128'(hv_cnt - hv0), 128'd2);
    check("t3_row_random", 128'(rr_bad - rr0), 128'd0);

    // 4: row unit never answers
    stub_en = 1'b0;
    snap();
    start_hash(1'b0);
    repeat (56) @(negedge clk);
    check("t4_err_c57", 128'({bus.err, bus.busy}), 128'b01);
    @(negedge clk);
    check("t4_err_c58", 128'({bus.err, bus.busy}), 128'b10);
    repeat (900) @(negedge clk);
    check("t4_no_hv", 128'(hv_cnt - hv0), 128'd0);
    check("t4_err_sticky", 128'(bus.err), 128'd1);
    start_hash(1'b0);
    check("t4_err_cleared", 128'(bus.err), 128'd0);
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    stub_en = 1'b1;
    @(negedge clk);

    // 5: reset during FEED of row 5, then rerun scenario 1
    msg = 16'hFFFF;
    fill_const(ones_w);
    start_hash(1'b0);
    repeat (279) @(negedge clk);
    part = '0;
    for (int k = 0; k < 5; k++) part[6*k +: 6] = 6'd16;
    check("t5_in_feed", 128'(bus.rnd_en), 128'd1);
    check("t5_partial_hash", 128'(bus.hash_out), 128'(part));
    #2 reset = 1'b1;
    #1;
    check("t5_async_strobes", 128'({bus.busy, bus.rnd_en, bus.row_start, bus.err}), 128'd0);
    check("t5_async_hash", 128'(bus.hash_out), 128'd0);
    check("t5_async_random", 128'(bus.row_random), 128'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    snap();
    start_hash(1'b0);
    wait_hv("t5");
    check("t5_hv_cycle", 128'(cyc - go_cyc), 128'd881);
    check("t5_hash", 128'(bus.hash_out), 128'(h16));
    @(negedge clk);
    check("t5_rnd_en_count", 128'(en_cnt - en0), 128'd848);
    check("t5_busy_drop", 128'(busy_drop - bd0), 128'd0);

    // 6: zero message, distinct lanes
    msg = 16'h0000;
    fill_const(lane_w);
    snap();
    start_hash(1'b0);
    repeat (10) @(negedge clk);
    check("t6_feed_word", 128'(bus.row_random), 128'(lane_w));
    check("t6_lane5", 128'(bus.row_random[35:30]), 128'd6);
    wait_hv("t6");
    check("t6_hv_cycle", 128'(cyc - go_cyc), 128'd881);
    check("t6_hash", 128'(bus.hash_out), 128'd0);
    @(negedge clk);
    check("t6_row_random", 128'(rr_bad - rr0), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
